// File: rtl/l2cache_nway.sv
// l2cache_nway: N-way set-associative write-back, write-allocate L2 cache with tree pseudo-LRU.
// One line is 256 bits. Tag and data arrays have no reset. Valid, dirty and PLRU bits do.
module l2cache_nway #(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [255:0] mem_wdata,
  input  logic [31:0]  mem_byte_enable,
  output logic [255:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int TAG_BITS = 27 - SET_BITS;
  localparam int SETS     = 1 << SET_BITS;
  localparam int LW       = $clog2(WAYS);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;
  localparam logic [1:0] S_FILL  = 2'd3;

  logic [1:0]                      r_state;
  logic [26:0]                     r_line;
  logic [255:0]                    r_wdata;
  logic [31:0]                     r_be;
  logic                            r_wr;
  logic [LW-1:0]                   r_victim;
  logic [255:0]                    r_pmem_wdata;
  logic [SETS-1:0][WAYS-1:0]       r_valid;
  logic [SETS-1:0][WAYS-1:0]       r_dirty;
  logic [SETS-1:0][WAYS-2:0]       r_plru;
  logic [255:0]                    r_data [WAYS][SETS];
  logic [TAG_BITS-1:0]             r_tag  [WAYS][SETS];

  logic [SET_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0] w_tag;
  logic                w_hit;
  logic                w_inv;
  logic [LW-1:0]       w_hit_way;
  logic [LW-1:0]       w_inv_way;
  logic [LW-1:0]       w_victim;
  logic [255:0]        w_hit_line;
  logic [255:0]        w_merged;
  logic                w_unused;

  // Heap-ordered tree: node n has children 2n+1 (lower ways) and 2n+2 (higher ways).
  function automatic logic [LW-1:0] plru_victim(input logic [WAYS-2:0] t);
    int n = 0;
    for (int l = 0; l < LW; l++) n = 2 * n + 1 + int'(t[n]);
    return LW'(n - (WAYS - 1));
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t, input logic [LW-1:0] w);
    logic [WAYS-2:0] r = t;
    int n = 0;
    for (int l = LW - 1; l >= 0; l--) begin
      r[n] = ~w[l];
      n = 2 * n + 1 + int'(w[l]);
    end
    return r;
  endfunction

  assign w_idx    = r_line[SET_BITS-1:0];
  assign w_tag    = r_line[26:SET_BITS];
  assign w_unused = ^mem_address[4:0];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_valid[w_idx][i] && r_tag[i][w_idx] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = LW'(i);
      end
      if (!r_valid[w_idx][i]) begin
        w_inv     = 1'b1;
        w_inv_way = LW'(i);
      end
    end
  end

  assign w_hit_line = r_data[w_hit_way][w_idx];
  assign w_victim   = w_inv ? w_inv_way : plru_victim(r_plru[w_idx]);

  always_comb begin
    w_merged = w_hit_line;
    for (int b = 0; b < 32; b++) if (r_be[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
  end

  assign mem_resp     = (r_state == S_CHECK) && w_hit;
  assign mem_rdata    = mem_resp ? w_hit_line : '0;
  assign pmem_write   = r_state == S_WB;
  assign pmem_read    = r_state == S_FILL;
  assign pmem_address = pmem_write ? {r_tag[r_victim][w_idx], w_idx, 5'b0} :
                        pmem_read  ? {r_line, 5'b0} : '0;
  assign pmem_wdata   = r_pmem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_line       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_wr         <= 1'b0;
      r_victim     <= '0;
      r_pmem_wdata <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_plru       <= '0;
    end else begin
      if (r_state == S_IDLE && (mem_read || mem_write)) begin
        r_line  <= mem_address[31:5];
        r_wdata <= mem_wdata;
        r_be    <= mem_byte_enable;
        r_wr    <= mem_write;
        r_state <= S_CHECK;
      end
      if (r_state == S_CHECK && w_hit) begin
        r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
        if (r_wr) r_dirty[w_idx][w_hit_way] <= 1'b1;
        r_state <= S_IDLE;
      end
      if (r_state == S_CHECK && !w_hit) begin
        r_victim     <= w_victim;
        r_pmem_wdata <= r_data[w_victim][w_idx];
        r_state      <= (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ? S_WB : S_FILL;
      end
      if (r_state == S_WB && pmem_resp) r_state <= S_FILL;
      if (r_state == S_FILL && pmem_resp) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
        r_state                  <= S_CHECK;
      end
    end
  end

  // Arrays only change in CHECK/FILL, which reset forces out of, so no partial line lands.
  always_ff @(posedge clk) begin
    if (r_state == S_CHECK && w_hit && r_wr) r_data[w_hit_way][w_idx] <= w_merged;
    if (r_state == S_FILL && pmem_resp) begin
      r_data[r_victim][w_idx] <= pmem_rdata;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
  end
endmodule
